fifo_burst_reader: RTL
======================

// Module: fifo_burst_reader
// PURPOSE
//  Read-side engine for the push/pull FIFO. On a start command it pops exactly
//  burst_len words from the FIFO's pull port and forwards them on a valid/ready
//  stream. A one-word output register decouples the stream from the FIFO.
//  Sits between the FIFO's dataout/empty/pull signals and a downstream consumer.
// PARAMETERS
//  DATA_W  31  word width; matches the FIFO storage width
//  LEN_W   8   width of burst_len and words_left
//  STALL_W 16  width of the saturating stall counter
// PORTS
//  clk          in   1        clock; all state updates on posedge
//  rst          in   1        reset; asynchronous, active-high
//  start        in   1        1-cycle command; sampled only in IDLE
//  burst_len    in   LEN_W    words to read; sampled with start
//  abort        in   1        synchronous abort of the current burst
//  fifo_empty   in   1        FIFO empty flag
//  fifo_dataout in   DATA_W   FIFO head word; valid whenever !fifo_empty
//  fifo_pull    out  1        pop request; the FIFO pops at the same posedge
//  out_valid    out  1        output word valid
//  out_data     out  DATA_W   output word
//  out_ready    in   1        consumer accepts when out_valid & out_ready
//  busy         out  1        high in RUN or FLUSH
//  done         out  1        1-cycle pulse when a burst completes normally
//  aborted      out  1        1-cycle pulse when a burst ends by abort
//  words_left   out  LEN_W    pops still to issue in this burst
//  stall_cnt    out  STALL_W  RUN cycles with fifo_empty=1; saturating
// BEHAVIOUR
//  Reset values: state=IDLE; fifo_pull=0 (comb), out_valid=0, out_data=0,
//   busy=0, done=0, aborted=0, words_left=0, stall_cnt=0.
//   Reset mid-burst discards any held word; no done or aborted pulse.
//  States:
//   IDLE : start=1 -> words_left<=burst_len, stall_cnt<=0.
//          If burst_len!=0, go to RUN. If burst_len==0, stay IDLE and pulse done next cycle.
//   RUN  : pop = !fifo_empty & words_left!=0 & (!out_valid | out_ready).
//          fifo_pull = pop (combinational).
//          On pop: out_data<=fifo_dataout, out_valid<=1, words_left<=words_left-1.
//          words_left 1->0 on a pop: go to FLUSH.
//          fifo_empty=1 in RUN: stall_cnt+1, saturating at all-ones.
//   FLUSH: fifo_pull=0. When out_valid & out_ready (or out_valid already 0):
//          go to IDLE and pulse done.
//  Output register: if there is no pop and out_valid & out_ready, then out_valid<=0.
//   Pop and accept in the same cycle keep out_valid=1 with the new word,
//   so throughput is 1 word/clk.
//  Latency: a word popped at edge N appears on out_data after edge N.
//  out_data is held stable while out_valid & !out_ready.
//  fifo_pull is never asserted when fifo_empty=1, in IDLE or FLUSH,
//   or when words_left==0.
//  abort (RUN or FLUSH): fifo_pull forced 0 that cycle; out_valid<=0; words_left<=0;
//   go to IDLE and pulse aborted. The held word is dropped.
//   abort in IDLE: no effect. abort has priority over start and pop.
//  start while busy: ignored. burst_len is latched only at start.
//  words_left arithmetic: unsigned LEN_W, never decremented below 0.
// TESTING
//  1 burst_len=4, FIFO holds 0xA..0xD, out_ready=1:
//    pull high for 4 consecutive cycles; out_data=A,B,C,D back-to-back; done 1 cycle after D accepted.
//  2 burst_len=3, out_ready low 5 cycles after the first word:
//    exactly 1 pop, then pull=0; out_data=first word held stable; resumes on ready.
//  3 burst_len=2, FIFO empty for 7 cycles, then 2 pushes:
//    stall_cnt=7; no pull while empty; both words delivered; done.
//  4 burst_len=0 -> no pull, done pulses next cycle. Start while busy -> ignored.
//  5 abort after 2 of 6 pops -> aborted=1, out_valid=0, words_left=0, IDLE; FIFO retains the remaining 4 words.
//  6 rst asserted mid-burst -> all outputs at reset values immediately.
//    A new burst after reset completes correctly.

Source files
------------

// File: rtl/fifo_burst_reader_if.sv
// Bundle of the command, FIFO-read and output-stream signals of the
// FIFO burst reader.
//   master : the reader engine (drives fifo_pull, the output stream and status)
//   slave  : the environment (issues commands, owns the FIFO, consumes words)
// Signals:
//   start, burst_len, abort        command from the controller
//   fifo_empty, fifo_dataout       FIFO read-side status and head word
//   fifo_pull                      pop request to the FIFO
//   out_valid, out_data, out_ready valid/ready output stream
//   busy, done, aborted            burst status
//   words_left, stall_cnt          progress and stall monitoring
interface fifo_burst_reader_if #(
  parameter int DATA_W  = 31,
  parameter int LEN_W   = 8,
  parameter int STALL_W = 16
);
  logic               start;
  logic [LEN_W-1:0]   burst_len;
  logic               abort;
  logic               fifo_empty;
  logic [DATA_W-1:0]  fifo_dataout;
  logic               fifo_pull;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic               aborted;
  logic [LEN_W-1:0]   words_left;
  logic [STALL_W-1:0] stall_cnt;

  modport master (
    input  start, burst_len, abort, fifo_empty, fifo_dataout, out_ready,
    output fifo_pull, out_valid, out_data, busy, done, aborted,
           words_left, stall_cnt
  );

  modport slave (
    output start, burst_len, abort, fifo_empty, fifo_dataout, out_ready,
    input  fifo_pull, out_valid, out_data, busy, done, aborted,
           words_left, stall_cnt
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side engine for the push/pull FIFO. A start command pops exactly
// burst_len words from the FIFO and forwards them on a valid/ready stream
// through a one-word output register, sustaining one word per clock.
// Ports:
//   clk  : clock, all state changes on posedge
//   rst  : asynchronous, active-high reset
//   bus  : fifo_burst_reader_if.master (command, FIFO read side, output
//          stream, status); fifo_pull is combinational, everything else
//          is registered.
module fifo_burst_reader #(
  parameter int DATA_W  = 31,
  parameter int LEN_W   = 8,
  parameter int STALL_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  fifo_burst_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [LEN_W-1:0]   LEN_ONE   = 1;
  localparam logic [STALL_W-1:0] STALL_ONE = 1;

  state_t             state;
  logic               out_valid_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               busy_q;
  logic               done_q;
  logic               aborted_q;
  logic [LEN_W-1:0]   words_left_q;
  logic [STALL_W-1:0] stall_q;

  logic pop;
  logic accept;
  logic abort_now;

  // abort only matters while a burst is in flight; it also blocks the pop
  assign abort_now = bus.abort && (state != IDLE);
  assign accept    = out_valid_q && bus.out_ready;
  // A pop is allowed when the output register is empty or is being drained
  // in this same cycle, which gives back-to-back throughput.
  assign pop = (state == RUN) && !bus.abort && !bus.fifo_empty &&
               (words_left_q != '0) && (!out_valid_q || bus.out_ready);

  assign bus.fifo_pull  = pop;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
  assign bus.words_left = words_left_q;
  assign bus.stall_cnt  = stall_q;

  // NOTE: every register here uses non-blocking assignments so all of them
  // see the pre-edge values, matching the flip-flops they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      out_valid_q  <= 1'b0;
      // NOTE: the data register is reset too, so out_data starts at a
      // defined value instead of X after reset.
      out_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      words_left_q <= '0;
      stall_q      <= '0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;

      // Output register: load on pop, otherwise empty it once accepted.
      if (pop) begin
        out_data_q  <= bus.fifo_dataout;
        out_valid_q <= 1'b1;
      end else if (accept) begin
        out_valid_q <= 1'b0;
      end

      if (abort_now) begin
        // The held word is dropped; the FIFO keeps whatever was not popped.
        out_valid_q  <= 1'b0;
        words_left_q <= '0;
        busy_q       <= 1'b0;
        aborted_q    <= 1'b1;
        state        <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              words_left_q <= bus.burst_len;
              stall_q      <= '0;
              if (bus.burst_len != '0) begin
                busy_q <= 1'b1;
                state  <= RUN;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          RUN: begin
            if (pop) begin
              words_left_q <= words_left_q - LEN_ONE;
              if (words_left_q == LEN_ONE) state <= FLUSH;
            end
            if (bus.fifo_empty && (stall_q != '1)) stall_q <= stall_q + STALL_ONE;
          end
          FLUSH: begin
            // Finish once the last word has left the output register.
            if (!out_valid_q || bus.out_ready) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
